// File: rtl/compressed_lwsp_loader.sv
// compressed_lwsp_loader: executes one RVC c.lwsp instruction.
// Decodes the 16-bit word and forms the stack-relative byte address.
// Issues a single RAM word read with a bounded wait for the data.
// Writes the returned word back to rd; errors end in a one-cycle ERR pulse.
module compressed_lwsp_loader (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSTART,
  input  logic [15:0] iIR,
  input  logic [31:0] iRS1,
  output logic [4:0]  oRS1,
  output logic        oRAM_CE,
  output logic        oRAM_RD,
  output logic        oRAM_WR,
  output logic [7:0]  oRAM_ADDR,
  input  logic        iRAM_GNT,
  input  logic        iRAM_RVALID,
  input  logic [31:0] iRAM_DATA,
  output logic [4:0]  oRD,
  output logic [31:0] oRD_DATA,
  output logic        oRD_WE,
  output logic        oBUSY,
  output logic        oDONE,
  output logic        oILLEGAL,
  output logic        oFAULT
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_WB   = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  // Last WAIT cycle index; the 15th WAIT cycle without data ends the read.
  localparam logic [3:0] WAIT_LAST = 4'd14;

  state_t      state_q, state_d;
  logic [4:0]  rd_q, rd_d;          // rd of the accepted instruction
  logic [7:0]  addr_q, addr_d;      // word address of the accepted instruction
  logic [3:0]  cnt_q, cnt_d;        // WAIT cycle counter
  logic        ill_q, ill_d;        // ERR cause: 1 = illegal, 0 = fault
  logic [4:0]  rd_out_q, rd_out_d;  // rd presented with the last write-back
  logic [31:0] data_q, data_d;      // word presented with the last write-back

  logic        dec_legal;
  logic [7:0]  dec_offset;
  logic [31:0] byte_addr;
  logic        misaligned;
  logic        addr_hi_unused;

  // Decode of the live instruction word; only consulted when a start is accepted.
  assign dec_legal  = (iIR[1:0] == 2'b10) && (iIR[15:13] == 3'b010) &&
                      (iIR[11:7] != 5'd0);
  assign dec_offset = {iIR[3:2], iIR[12], iIR[6:4], 2'b00};
  assign byte_addr  = iRS1 + {24'h0, dec_offset};
  assign misaligned = |byte_addr[1:0];
  // RAM is word addressed over 256 words; upper address bits are discarded.
  assign addr_hi_unused = ^byte_addr[31:10];

  // State and datapath registers; reset clears everything, including held outputs.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q  <= S_IDLE;
      rd_q     <= 5'd0;
      addr_q   <= 8'd0;
      cnt_q    <= 4'd0;
      ill_q    <= 1'b0;
      rd_out_q <= 5'd0;
      data_q   <= 32'h0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      ill_q    <= ill_d;
      rd_out_q <= rd_out_d;
      data_q   <= data_d;
    end
  end

  // Next-state logic: accept, request, wait with timeout, write back or error.
  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    ill_d    = ill_q;
    rd_out_d = rd_out_q;
    data_d   = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (iSTART) begin
          rd_d   = iIR[11:7];
          addr_d = byte_addr[9:2];
          if (!dec_legal) begin
            ill_d   = 1'b1;
            state_d = S_ERR;
          end else if (misaligned) begin
            ill_d   = 1'b0;
            state_d = S_ERR;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (iRAM_GNT) begin
          cnt_d   = 4'd0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (iRAM_RVALID) begin
          data_d   = iRAM_DATA;
          rd_out_d = rd_q;
          state_d  = S_WB;
        end else if (cnt_q == WAIT_LAST) begin
          ill_d   = 1'b0;
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_WB:    state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign oRS1      = 5'h2;
  assign oRAM_WR   = 1'b0;
  assign oRAM_CE   = (state_q == S_REQ);
  assign oRAM_RD   = (state_q == S_REQ);
  assign oRAM_ADDR = addr_q;
  assign oRD       = rd_out_q;
  assign oRD_DATA  = data_q;
  assign oRD_WE    = (state_q == S_WB);
  assign oDONE     = (state_q == S_WB);
  assign oBUSY     = (state_q != S_IDLE);
  assign oILLEGAL  = (state_q == S_ERR) && ill_q;
  assign oFAULT    = (state_q == S_ERR) && !ill_q;

endmodule

// File: doc/compressed_lwsp_loader.md
COMPRESSED_LWSP_LOADER -- requirements
Module: compressed_lwsp_loader

Interface
REQ-001 The block SHALL have one clock, iCLK; reset is synchronous and active-high, iRST.
REQ-002 Ports SHALL be, one per line:
- iCLK  in  1  clock; all state updates on rising edge.
- iRST  in  1  synchronous active-high reset.
- iSTART  in  1  one-cycle request to execute iIR; sampled only in IDLE.
- iIR  in  16  compressed instruction word.
- iRS1  in  32  register-file read data for oRS1 (stack pointer value).
- oRS1  out  5  register-file read index; constant 5'h2 (sp).
- oRAM_CE  out  1  RAM chip enable.
- oRAM_RD  out  1  RAM read strobe.
- oRAM_WR  out  1  RAM write strobe; constant 0.
- oRAM_ADDR  out  8  RAM word address.
- iRAM_GNT  in  1  RAM accepted the read request this cycle.
- iRAM_RVALID  in  1  iRAM_DATA valid this cycle.
- iRAM_DATA  in  32  RAM read data.
- oRD  out  5  destination register index.
- oRD_DATA  out  32  write-back data.
- oRD_WE  out  1  register-file write enable, one-cycle pulse.
- oBUSY  out  1  high in any state other than IDLE.
- oDONE  out  1  one-cycle pulse on successful completion.
- oILLEGAL  out  1  one-cycle pulse: not a legal c.lwsp.
- oFAULT  out  1  one-cycle pulse: misaligned address or RAM timeout.

Function
REQ-003 Decode: legal iff iIR[1:0]=2'b10, iIR[15:13]=3'b010, rd=iIR[11:7]!=0.
REQ-004 Offset SHALL be 8-bit zero-extended {iIR[3:2], iIR[12], iIR[6:4], 2'b00}; byte address = iRS1 + offset, 32-bit, wrap modulo 2^32.
REQ-005 oRAM_ADDR SHALL be byte address bits [9:2]; higher bits discarded.
REQ-006 iIR, rd and byte address SHALL be registered when iSTART accepted; later changes to iIR/iRS1 have no effect on the operation.
REQ-007 States: IDLE, REQ, WAIT, WB, ERR.
REQ-008 IDLE + iSTART + illegal -> ERR with oILLEGAL=1 for one cycle, no RAM access.
REQ-009 IDLE + iSTART + legal + byte address[1:0]!=0 -> ERR with oFAULT=1 for one cycle, no RAM access.
REQ-010 IDLE + iSTART + legal + aligned -> REQ.
REQ-011 REQ: oRAM_CE=1, oRAM_RD=1, oRAM_ADDR stable; held until iRAM_GNT=1, then -> WAIT.
REQ-012 WAIT: oRAM_CE=oRAM_RD=0; on iRAM_RVALID capture iRAM_DATA, -> WB.
REQ-013 WAIT timeout: 4-bit counter cleared on entry; if 15 cycles elapse without iRAM_RVALID -> ERR with oFAULT=1; late RVALID ignored.
REQ-014 WB (one cycle): oRD_WE=1, oDONE=1, oRD=latched rd, oRD_DATA=captured word; -> IDLE.
REQ-015 ERR (one cycle) -> IDLE; oRD_WE=0.
REQ-016 iSTART outside IDLE SHALL be ignored (no queuing).
REQ-017 iRAM_RVALID outside WAIT and iRAM_GNT outside REQ SHALL be ignored.
REQ-018 Minimum latency: iSTART sampled at edge k, iRAM_GNT in REQ cycle k+1, iRAM_RVALID in first WAIT cycle k+2 -> oRD_WE high during cycle k+3.
REQ-019 oRD_DATA and oRD SHALL hold their last value outside WB; only oRD_WE qualifies them.

Reset
REQ-020 iRST high at a clock edge SHALL force IDLE from any state, abandoning any in-flight read.
REQ-021 After reset: oRAM_CE, oRAM_RD, oRD_WE, oBUSY, oDONE, oILLEGAL, oFAULT = 0; oRAM_ADDR, oRD = 0; oRD_DATA = 32'h0; timeout counter = 0.
REQ-022 Data returned after reset for an abandoned read SHALL not cause a write-back.

Verification
REQ-023 iRS1=32'h100, iIR=16'h4512 (c.lwsp a0,4(sp)), GNT and RVALID immediate, data 32'hDEADBEEF -> oRAM_ADDR=8'h41, oRD=10, oRD_DATA=32'hDEADBEEF, oRD_WE at k+3.
REQ-024 iIR=16'h4012 (rd=0) -> oILLEGAL pulse, oRAM_CE never asserted, no oRD_WE.
REQ-025 iRS1=32'h102, legal lwsp -> oFAULT pulse, no RAM access, oBUSY low after one cycle.
REQ-026 GNT delayed 3 cycles, RVALID 5 cycles later -> oRAM_CE/oRAM_RD held 4 cycles, single oRD_WE, second iSTART during busy ignored.
REQ-027 RVALID never returned -> oFAULT after 15 WAIT cycles, IDLE; late RVALID produces no write-back.
REQ-028 iRST asserted in WAIT -> all outputs reset next cycle; following RVALID produces no oRD_WE.
